// File: rtl/stream_pkt_fifo.sv
// Circular packet buffer behind a crossbar master port. In packet mode, words are
// held back until a whole packet (or a full buffer) is stored.
module stream_pkt_fifo #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_ID___WIDTH = 1,
    parameter int DEPTH        = 8,
    parameter int PACKET_MODE  = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_ID___WIDTH-1:0] s_id_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [AW:0]             fill_o,
    output logic [AW:0]             pkt_cnt_o
);

    localparam int EW = T_DATA_WIDTH + T_ID___WIDTH + 1;
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW:0]   wp_r;
    logic [AW:0]   rp_r;
    logic [AW:0]   fill_r;
    logic [AW:0]   pkt_cnt_r;
    logic          init_r;

    logic          empty_s;
    logic          full_s;
    logic          wr_s;
    logic          rd_s;
    logic [EW-1:0] head_s;
    logic          head_last_s;

    assign empty_s     = (wp_r == rp_r);
    assign full_s      = (wp_r[AW-1:0] == rp_r[AW-1:0]) && (wp_r[AW] != rp_r[AW]);
    assign head_s      = mem_r[rp_r[AW-1:0]];
    assign head_last_s = head_s[EW-1];

    // A full buffer with no complete packet is released cut-through so it cannot deadlock.
    assign s_ready_o = init_r & ~full_s;
    assign m_valid_o = ~empty_s & ((PACKET_MODE == 0) | (pkt_cnt_r != PTR_ZERO) | full_s);
    assign m_data_o  = head_s[T_DATA_WIDTH-1:0];
    assign m_id_o    = head_s[T_DATA_WIDTH +: T_ID___WIDTH];
    assign m_last_o  = head_last_s & ~empty_s;
    assign fill_o    = fill_r;
    assign pkt_cnt_o = pkt_cnt_r;

    assign wr_s = s_valid_i & s_ready_o;
    assign rd_s = m_valid_o & m_ready_i;

    // Storage array write port; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wp_r[AW-1:0]] <= {s_last_i, s_id_i, s_data_i};
        end
    end

    // Pointers, init flag and occupancy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r      <= PTR_ZERO;
            rp_r      <= PTR_ZERO;
            fill_r    <= PTR_ZERO;
            pkt_cnt_r <= PTR_ZERO;
            init_r    <= 1'b0;
        end else begin
            init_r <= 1'b1;
            if (wr_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (rd_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            case ({wr_s, rd_s})
                2'b10:   fill_r <= fill_r + PTR_ONE;
                2'b01:   fill_r <= fill_r - PTR_ONE;
                default: fill_r <= fill_r;
            endcase
            case ({wr_s & s_last_i, rd_s & head_last_s})
                2'b10:   pkt_cnt_r <= pkt_cnt_r + PTR_ONE;
                2'b01:   pkt_cnt_r <= pkt_cnt_r - PTR_ONE;
                default: pkt_cnt_r <= pkt_cnt_r;
            endcase
        end
    end

endmodule

// File: doc/stream_pkt_fifo.md
Name: stream_pkt_fifo

Overview:
- Per-output packet buffer placed directly downstream of each crossbar master port.
- Accepts the crossbar output stream (data, id, last) and stores it in a circular buffer.
- Re-presents the stream to the sink with a valid/ready handshake, decoupling sink back-pressure from crossbar arbitration.
- In packet mode it holds words back until the whole packet is stored, so the sink never sees a stalled partial packet.

Parameters:
- T_DATA_WIDTH, 8: data width in bits.
- T_ID___WIDTH, 1: source-id width in bits; matches the crossbar m_id_o width.
- DEPTH, 8: buffer entries. Must be a power of two and at least 2.
- PACKET_MODE, 1: 1 = store-and-forward per packet; 0 = plain FIFO (cut-through).
- Localparam AW = $clog2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data_i  input  T_DATA_WIDTH  input data word.
- s_id_i  input  T_ID___WIDTH  source id of the word.
- s_last_i  input  1  last word of the packet.
- s_valid_i  input  1  input word valid.
- s_ready_o  output  1  buffer can accept a word.
- m_data_o  output  T_DATA_WIDTH  head data word.
- m_id_o  output  T_ID___WIDTH  head id.
- m_last_o  output  1  head is the last word of its packet.
- m_valid_o  output  1  head word presented to the sink.
- m_ready_i  input  1  sink accepts the head word.
- fill_o  output  AW+1  number of stored words, 0..DEPTH.
- pkt_cnt_o  output  AW+1  number of complete packets stored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, fill and pkt_cnt clear to 0.
  - Internal init flag clears to 0.
  - Outputs while in reset: s_ready_o=0, m_valid_o=0, m_last_o=0, fill_o=0, pkt_cnt_o=0.
  - m_data_o and m_id_o are don't-care; the bench must not check them while m_valid_o=0.
- Init: the flag sets on the first clk edge after rst_n rises. s_ready_o therefore first goes high one cycle after reset release.
- Storage: write pointer wp and read pointer rp, each AW+1 bits; the MSB is the wrap bit.
  - empty = (wp==rp).
  - full = (wp[AW-1:0]==rp[AW-1:0]) and MSBs differ.
  - Each entry holds {last, id, data}.
- Write: the handshake is s_valid_i & s_ready_o, with s_ready_o = init & !full (combinational).
  - On a handshake the entry is written at wp[AW-1:0] and wp increments.
  - No write occurs when full, even if the sink pops in the same cycle. There is no ready-through-pop path; this avoids a combinational m_ready_i -> s_ready_o path.
- Read: head = entry at rp[AW-1:0], read combinationally. m_data_o, m_id_o and m_last_o reflect the head.
  - m_valid_o = !empty & (PACKET_MODE==0 | pkt_cnt!=0 | full).
  - On m_valid_o & m_ready_i, rp increments.
  - Once m_valid_o is high it stays high and the head stays stable until accepted.
- Counters:
  - fill: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - pkt_cnt: +1 on a write with s_last_i=1, -1 on a read with the head last=1, unchanged if both happen in the same cycle.
  - pkt_cnt never exceeds fill.
- Oversize packet (packet mode): if the buffer fills with no last stored (pkt_cnt=0, full), m_valid_o asserts and the packet drains in cut-through fashion. This prevents deadlock. Packet mode resumes automatically once that packet's last word is read.
- Pointer wrap: pointers wrap modulo 2*DEPTH. Full/empty detection must be correct across the wrap, including immediately after DEPTH consecutive writes.
- Latency: a word written in cycle N is visible at the head no earlier than cycle N+1. There is no same-cycle bypass.
- Reset mid-packet: all contents are discarded. After reset the buffer is empty and any partial packet is lost; upstream restarts.
- Assertions for the verifier:
  - No write when full; no read when empty.
  - fill_o == wp - rp.
  - m_data_o, m_id_o, m_last_o stable while m_valid_o & !m_ready_i.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release -> s_ready_o=0 in the first cycle after release, 1 from the second; m_valid_o=0; fill_o=0.
- Packet mode, 3-word packet 0x11, 0x22, 0x33 (last on 0x33, id=1), m_ready_i=1:
  - m_valid_o stays 0 until the cycle after 0x33 is written.
  - The sink then receives 0x11, 0x22, 0x33 on consecutive cycles, with m_last_o only on 0x33 and m_id_o=1.
- Fill and wrap, PACKET_MODE=0, DEPTH=8: write 8 single-word packets 0..7 with m_ready_i=0.
  - Required: fill_o=8, s_ready_o=0, pkt_cnt_o=8.
  - Pop 3, write 3 more (8..10), pop all -> order is 3..10 and fill_o ends at 0.
- Oversize packet, packet mode, DEPTH=8: 12-word packet with m_ready_i=1.
  - m_valid_o rises once fill_o=8.
  - All 12 words are delivered in order, with last only on word 12, and no deadlock.
- Simultaneous write and read with fill_o=4 and pkt_cnt_o=2: write a last word while popping a last word -> fill_o=4 and pkt_cnt_o=2 the next cycle.
- Random back-pressure: 200 packets of 1..6 words, random s_valid_i and m_ready_i -> output sequence equals input sequence, and the stability assertions never fire.
